al4s3b_wb_initiator: RTL and testbench
======================================

# al4s3b_wb_initiator

Wishbone initiator that turns single-word read/write requests from a local valid/ready command port into Wishbone classic cycles on the fabric bus, then returns read data or an error on a valid/ready response port. It sits opposite the fabric IP slaves (register blocks, GPIO controller, QL reserved block). It lets an on-fabric sequencer, test engine or DMA helper drive the same 17-bit byte-addressed Wishbone map that the M4 bridge uses.

## Interface
Parameters:
- ADDRWIDTH, 17, byte address width
- DATAWIDTH, 32, data width; byte strobes are DATAWIDTH/8
- TIMEOUT_CNTR_WIDTH, 3, timeout counter width
- TIMEOUT_CYCLES, 7, bus cycles without ACK before abort; legal range 1..2^TIMEOUT_CNTR_WIDTH-1
- TIMEOUT_READ_VALUE, 32'hBAD_FAB_AC, Rsp_DAT_o value on timeout

Ports:
- WBs_CLK_i  in  1  clock; one clock domain
- WBs_RST_i  in  1  reset, synchronous, active-high
- Req_Valid_i  in  1  request valid
- Req_Ready_o  out  1  request accepted when Valid&Ready
- Req_WE_i  in  1  1 = write, 0 = read
- Req_ADR_i  in  ADDRWIDTH  byte address
- Req_BYTE_STB_i  in  4  byte enables (writes); ignored on reads, which drive 4'hF
- Req_DAT_i  in  DATAWIDTH  write data
- Rsp_Valid_o  out  1  response valid
- Rsp_Ready_i  in  1  response consumed when Valid&Ready
- Rsp_DAT_o  out  DATAWIDTH  read data (0 for a successful write)
- Rsp_Err_o  out  1  1 = timed out
- WBm_ADR_o  out  ADDRWIDTH  bus address; [1:0] forced to 0
- WBm_CYC_o, WBm_STB_o  out  1  cycle and strobe, always equal
- WBm_WE_o, WBm_RD_o  out  1  write / read qualifiers; RD = CYC & ~WE
- WBm_BYTE_STB_o  out  4  byte select
- WBm_DAT_o  out  DATAWIDTH  write data
- WBm_DAT_i  in  DATAWIDTH  read data
- WBm_ACK_i  in  1  acknowledge
- Txn_Cnt_o  out  16  completed transactions, wraps 16'hFFFF→0

## Operation
- States: IDLE, BUS, RESP.
- IDLE: Req_Ready_o=1. On Valid&Ready, latch WE/ADR/BYTE_STB/DAT and go to BUS.
- BUS: CYC/STB/WE/RD/ADR/BYTE_STB/DAT are registered and stable for the whole cycle. Req_Ready_o=0.
  - On WBm_ACK_i, capture WBm_DAT_i for reads (0 for writes), clear Err, drop CYC/STB at that clock edge, and go to RESP.
  - Timeout counter clears on BUS entry and increments on each BUS cycle without ACK. When it equals TIMEOUT_CYCLES-1 with no ACK, abort: drop CYC/STB, set Rsp_DAT_o=TIMEOUT_READ_VALUE and Rsp_Err_o=1, go to RESP.
  - ACK in the same cycle as timeout expiry is a success; ACK wins.
- RESP: Rsp_Valid_o=1, with data and Err held stable. On Rsp_Ready_i, increment Txn_Cnt_o (for both success and error) and go to IDLE.
- WBm_ACK_i outside BUS is ignored.
- Reset mid-cycle forces IDLE and drops CYC/STB at the next edge. The pending response is discarded.

## Timing
- Reset values: Req_Ready_o=1 (IDLE); Rsp_Valid_o, Rsp_Err_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o=0; WBm_ADR_o, WBm_BYTE_STB_o, WBm_DAT_o, Rsp_DAT_o, Txn_Cnt_o=0.
- Request accepted at edge N: CYC/STB high from cycle N+1.
- ACK sampled at edge N+k: CYC low and Rsp_Valid_o high from N+k+1.
- Best-case throughput: one transaction per 3 cycles with Rsp_Ready_i held high.
- Timeout: CYC high for exactly TIMEOUT_CYCLES cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- WB_INITIATOR_TIMEOUT_EN defined: timeout counter and abort path present as described.
- Not defined: no counter; BUS waits for ACK indefinitely; Rsp_Err_o tied 0; TIMEOUT_* parameters unused.

## Structure
- Package al4s3b_wb_pkg holds:
  - state encoding (IDLE/BUS/RESP)
  - default values of TIMEOUT_READ_VALUE and TIMEOUT_CYCLES
  - byte-strobe width constant
- One sub-module, al4s3b_wb_timeout_cntr, with clear, enable and expired outputs. It is instantiated only under WB_INITIATOR_TIMEOUT_EN.

## Test plan
- Write: ADR 17'h04004, DAT 32'h0000_00A5, BYTE_STB 4'h1; slave ACKs 1 cycle after CYC. Required: bus shows WE=1, STB=4'h1; Rsp_Err=0, Rsp_DAT=0; Txn_Cnt=1.
- Read: ADR 17'h05003; slave returns 32'h0001_0000 on ACK after 3 wait cycles. Required: WBm_ADR_o=17'h05000, BYTE_STB=4'hF; Rsp_DAT=32'h0001_0000.
- No ACK, default parameters: CYC high exactly 7 cycles; Rsp_DAT=32'hBAD_FAB_AC, Rsp_Err=1. Without the macro, CYC stays high for 100+ cycles.
- ACK on the 7th bus cycle, coincident with expiry: Rsp_Err=0 and the slave data is returned.
- Backpressure: Rsp_Ready_i held low 5 cycles. Required: Rsp_Valid/DAT stable, Req_Ready_o=0, no new CYC.
- Reset asserted during BUS: CYC=0 and Req_Ready_o=1 the next cycle; Txn_Cnt=0. Also preload Txn_Cnt to 16'hFFFF; the next completion wraps it to 0.

Source files
------------

// File: rtl/al4s3b_wb_pkg.sv
// -----------------------------------------------------------------------------
// al4s3b_wb_pkg
// Shared definitions for the fabric Wishbone initiator:
//   - wb_state_e             : initiator FSM encoding (IDLE / BUS / RESP)
//   - TIMEOUT_CYCLES_DEF     : default bus cycles without ACK before abort
//   - TIMEOUT_READ_VALUE_DEF : default data returned on a timed-out access
//   - BYTE_STB_W             : byte-strobe width of the 32-bit fabric bus
// -----------------------------------------------------------------------------
package al4s3b_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int          TIMEOUT_CYCLES_DEF     = 7;
  localparam logic [31:0] TIMEOUT_READ_VALUE_DEF = 32'hBAD_FAB_AC;
  localparam int          BYTE_STB_W             = 4;

endpackage

// File: rtl/al4s3b_wb_timeout_cntr.sv
// -----------------------------------------------------------------------------
// al4s3b_wb_timeout_cntr
// Counts bus cycles spent waiting for ACK and flags the abort cycle.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clr_i      : hold the count at zero (asserted whenever no bus cycle runs)
//   en_i       : a bus cycle is running and no ACK was seen this cycle
//   expired_o  : this is the last permitted wait cycle; abort at this edge
// -----------------------------------------------------------------------------
module al4s3b_wb_timeout_cntr #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Count 0 is the first bus cycle, so LIMIT-1 is the LIMIT-th cycle.
  assign expired_o = en_i && (cnt_q == WIDTH'(LIMIT - 1));

endmodule

// File: rtl/al4s3b_wb_initiator.sv
// -----------------------------------------------------------------------------
// al4s3b_wb_initiator
// Turns single-word requests from a valid/ready command port into Wishbone
// classic cycles and returns read data / error on a valid/ready response port.
//
// Optional feature: define WB_INITIATOR_TIMEOUT_EN to add the no-ACK timeout
// abort path. Without it the bus waits for ACK forever and Rsp_Err_o is 0.
//
// Ports:
//   WBs_CLK_i / WBs_RST_i          clock, synchronous active-high reset
//   Req_*                          command port (Valid/Ready, WE, ADR, STB, DAT)
//   Rsp_*                          response port (Valid/Ready, DAT, Err)
//   WBm_*                          Wishbone initiator bus
//   Txn_Cnt_o                      completed transactions, wrapping 16-bit
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module al4s3b_wb_initiator
  import al4s3b_wb_pkg::*;
#(
  parameter int                   ADDRWIDTH          = 17,
  parameter int                   DATAWIDTH          = 32,
  parameter int                   TIMEOUT_CNTR_WIDTH = 3,
  parameter int                   TIMEOUT_CYCLES     = TIMEOUT_CYCLES_DEF,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = DATAWIDTH'(TIMEOUT_READ_VALUE_DEF)
) (
  input  logic                  WBs_CLK_i,
  input  logic                  WBs_RST_i,
  input  logic                  Req_Valid_i,
  output logic                  Req_Ready_o,
  input  logic                  Req_WE_i,
  input  logic [ADDRWIDTH-1:0]  Req_ADR_i,
  input  logic [BYTE_STB_W-1:0] Req_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0]  Req_DAT_i,
  output logic                  Rsp_Valid_o,
  input  logic                  Rsp_Ready_i,
  output logic [DATAWIDTH-1:0]  Rsp_DAT_o,
  output logic                  Rsp_Err_o,
  output logic [ADDRWIDTH-1:0]  WBm_ADR_o,
  output logic                  WBm_CYC_o,
  output logic                  WBm_STB_o,
  output logic                  WBm_WE_o,
  output logic                  WBm_RD_o,
  output logic [BYTE_STB_W-1:0] WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0]  WBm_DAT_o,
  input  logic [DATAWIDTH-1:0]  WBm_DAT_i,
  input  logic                  WBm_ACK_i,
  output logic [15:0]           Txn_Cnt_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**TIMEOUT_CNTR_WIDTH) - 1) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES must lie in 1..2**TIMEOUT_CNTR_WIDTH-1");
  end

  wb_state_e             state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic                  rd_q, rd_d;
  logic [ADDRWIDTH-1:0]  adr_q, adr_d;
  logic [BYTE_STB_W-1:0] stb_q, stb_d;
  logic [DATAWIDTH-1:0]  wdat_q, wdat_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]  rsp_dat_q, rsp_dat_d;
  logic                  err_q, err_d;
  logic [15:0]           txn_cnt_q, txn_cnt_d;
  logic                  timeout_hit;

`ifdef WB_INITIATOR_TIMEOUT_EN
  al4s3b_wb_timeout_cntr #(
    .WIDTH (TIMEOUT_CNTR_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cntr (
    .clk_i     (WBs_CLK_i),
    .rst_i     (WBs_RST_i),
    .clr_i     (state_q != ST_BUS),
    .en_i      ((state_q == ST_BUS) && !WBm_ACK_i),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through the block leaves a variable unassigned and no latch appears.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    rd_d        = rd_q;
    adr_d       = adr_q;
    stb_d       = stb_q;
    wdat_d      = wdat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    err_d       = err_q;
    txn_cnt_d   = txn_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Req_Valid_i) begin
          state_d = ST_BUS;
          ready_d = 1'b0;
          cyc_d   = 1'b1;
          we_d    = Req_WE_i;
          rd_d    = !Req_WE_i;
          // Word-aligned bus address; the low byte-lane bits are dropped.
          adr_d   = Req_ADR_i & ~ADDRWIDTH'(3);
          stb_d   = Req_WE_i ? Req_BYTE_STB_i : '1;
          wdat_d  = Req_DAT_i;
        end
      end

      ST_BUS: begin
        // ACK takes priority over an expiry in the same cycle.
        if (WBm_ACK_i) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rd_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = we_q ? '0 : WBm_DAT_i;
          err_d       = 1'b0;
        end else if (timeout_hit) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          rd_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = TIMEOUT_READ_VALUE;
          err_d       = 1'b1;
        end
      end

      ST_RESP: begin
        if (Rsp_Ready_i) begin
          state_d     = ST_IDLE;
          ready_d     = 1'b1;
          rsp_valid_d = 1'b0;
          txn_cnt_d   = txn_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        ready_d     = 1'b1;
        cyc_d       = 1'b0;
        rd_d        = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge WBs_CLK_i) begin
    if (WBs_RST_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      rd_q        <= 1'b0;
      adr_q       <= '0;
      stb_q       <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      err_q       <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      adr_q       <= adr_d;
      stb_q       <= stb_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      err_q       <= err_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  assign Req_Ready_o    = ready_q;
  assign Rsp_Valid_o    = rsp_valid_q;
  assign Rsp_DAT_o      = rsp_dat_q;
  assign Rsp_Err_o      = err_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_RD_o       = rd_q;
  assign WBm_BYTE_STB_o = stb_q;
  assign WBm_DAT_o      = wdat_q;
  assign Txn_Cnt_o      = txn_cnt_q;

endmodule

// File: tb/tb_al4s3b_wb_initiator.sv
`timescale 1ns/1ps
module tb_al4s3b_wb_initiator;

  localparam int AW = 17;
  localparam int DW = 32;

  logic          WBs_CLK_i = 1'b0;
  logic          WBs_RST_i;
  logic          Req_Valid_i, Req_Ready_o, Req_WE_i;
  logic [AW-1:0] Req_ADR_i;
  logic [3:0]    Req_BYTE_STB_i;
  logic [DW-1:0] Req_DAT_i;
  logic          Rsp_Valid_o, Rsp_Ready_i, Rsp_Err_o;
  logic [DW-1:0] Rsp_DAT_o;
  logic [AW-1:0] WBm_ADR_o;
  logic          WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o, WBm_ACK_i;
  logic [3:0]    WBm_BYTE_STB_o;
  logic [DW-1:0] WBm_DAT_o, WBm_DAT_i;
  logic [15:0]   Txn_Cnt_o;

  al4s3b_wb_initiator dut (
    .WBs_CLK_i      (WBs_CLK_i),
    .WBs_RST_i      (WBs_RST_i),
    .Req_Valid_i    (Req_Valid_i),
    .Req_Ready_o    (Req_Ready_o),
    .Req_WE_i       (Req_WE_i),
    .Req_ADR_i      (Req_ADR_i),
    .Req_BYTE_STB_i (Req_BYTE_STB_i),
    .Req_DAT_i      (Req_DAT_i),
    .Rsp_Valid_o    (Rsp_Valid_o),
    .Rsp_Ready_i    (Rsp_Ready_i),
    .Rsp_DAT_o      (Rsp_DAT_o),
    .Rsp_Err_o      (Rsp_Err_o),
    .WBm_ADR_o      (WBm_ADR_o),
    .WBm_CYC_o      (WBm_CYC_o),
    .WBm_STB_o      (WBm_STB_o),
    .WBm_WE_o       (WBm_WE_o),
    .WBm_RD_o       (WBm_RD_o),
    .WBm_BYTE_STB_o (WBm_BYTE_STB_o),
    .WBm_DAT_o      (WBm_DAT_o),
    .WBm_DAT_i      (WBm_DAT_i),
    .WBm_ACK_i      (WBm_ACK_i),
    .Txn_Cnt_o      (Txn_Cnt_o)
  );

  always #5 WBs_CLK_i = ~WBs_CLK_i;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          err;
  } exp_t;

  typedef struct {
    int            cyc_len;
    logic [AW-1:0] adr;
    logic [3:0]    stb;
    logic          we;
    logic          rd;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic          err;
    bit            got_rsp;
    bit            bus_bad;
    bit            hold_bad;
  } obs_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [15:0]   exp_txn  = 16'd0;

  // Slave model: ACK on the ack_on-th cycle of CYC (0 = never).
  int            ack_on = 0;
  int            cyc_n  = 0;
  bit            slave_addr_data = 1'b0;
  logic [DW-1:0] slave_rdata = '0;

  initial begin
    WBm_ACK_i = 1'b0;
    WBm_DAT_i = '0;
    forever begin
      @(negedge WBs_CLK_i);
      if (WBm_CYC_o) cyc_n++;
      else           cyc_n = 0;
      WBm_ACK_i = WBm_CYC_o && (ack_on != 0) && (cyc_n == ack_on);
      if (!WBm_ACK_i)          WBm_DAT_i = 32'hDEAD_DEAD;
      else if (slave_addr_data) WBm_DAT_i = 32'hC0DE_0000 | 32'(WBm_ADR_o);
      else                      WBm_DAT_i = slave_rdata;
    end
  end

  // Issues one request from a negedge, watches the bus, then collects the
  // response, holding Rsp_Ready_i low for `hold` extra cycles. Ends on a negedge.
  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [3:0] stb,
                         input logic [DW-1:0] dat, input int hold, output obs_t o);
    o = '{default: '0};
    Rsp_Ready_i    = (hold == 0);
    Req_Valid_i    = 1'b1;
    Req_WE_i       = we;
    Req_ADR_i      = adr;
    Req_BYTE_STB_i = stb;
    Req_DAT_i      = dat;
    for (int t = 0; t < 300 && !o.got_rsp; t++) begin
      @(negedge WBs_CLK_i);
      Req_Valid_i = 1'b0;
      if (WBm_CYC_o) begin
        if (o.cyc_len == 0) begin
          o.adr = WBm_ADR_o; o.stb = WBm_BYTE_STB_o; o.we = WBm_WE_o;
          o.rd  = WBm_RD_o;  o.wdat = WBm_DAT_o;
        end else if ({WBm_ADR_o, WBm_BYTE_STB_o, WBm_WE_o, WBm_RD_o, WBm_DAT_o} !==
                     {o.adr, o.stb, o.we, o.rd, o.wdat}) begin
          o.bus_bad = 1'b1;
        end
        if (WBm_STB_o !== 1'b1 || WBm_RD_o !== !WBm_WE_o || Req_Ready_o !== 1'b0)
          o.bus_bad = 1'b1;
        o.cyc_len++;
      end
      if (Rsp_Valid_o) begin
        o.rdat    = Rsp_DAT_o;
        o.err     = Rsp_Err_o;
        o.got_rsp = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(negedge WBs_CLK_i);
          if (Rsp_Valid_o !== 1'b1 || Rsp_DAT_o !== o.rdat || Rsp_Err_o !== o.err ||
              Req_Ready_o !== 1'b0 || WBm_CYC_o !== 1'b0)
            o.hold_bad = 1'b1;
        end
        Rsp_Ready_i = 1'b1;
        @(negedge WBs_CLK_i);
      end
    end
  endtask

  task automatic check_rsp(input string name, input obs_t o);
    exp_t e;
    n_checks++;
    if (!o.got_rsp || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_rsp_seen: got_rsp=%0d expected 1", name, o.got_rsp);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      if ({o.rdat, o.err} !== {e.dat, e.err}) begin
        n_fail++;
        $display("FAIL %s_rsp: dat=%h err=%b expected dat=%h err=%b", name, o.rdat, o.err, e.dat, e.err);
      end
    end
    n_checks++;
    if (o.bus_bad) begin
      n_fail++;
      $display("FAIL %s_bus_stable: unstable/inconsistent bus 1 expected 0", name);
    end
    n_checks++;
    if (Txn_Cnt_o !== exp_txn) begin
      n_fail++;
      $display("FAIL %s_txn_cnt: got %h expected %h", name, Txn_Cnt_o, exp_txn);
    end
  endtask

  task automatic apply_reset();
    WBs_RST_i = 1'b1;
    repeat (3) @(negedge WBs_CLK_i);
    WBs_RST_i = 1'b0;
    exp_txn = 16'd0;
    exp_q.delete();
    @(negedge WBs_CLK_i);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({Req_Ready_o, Rsp_Valid_o, Rsp_Err_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 1000000",
               {Req_Ready_o, Rsp_Valid_o, Rsp_Err_o, WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_RD_o});
    end
    n_checks++;
    if (WBm_ADR_o !== '0 || WBm_BYTE_STB_o !== '0 || WBm_DAT_o !== '0 || Rsp_DAT_o !== '0 || Txn_Cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: adr=%h stb=%h dat=%h rsp=%h cnt=%h expected all 0",
               WBm_ADR_o, WBm_BYTE_STB_o, WBm_DAT_o, Rsp_DAT_o, Txn_Cnt_o);
    end
  endtask

  task automatic test_write();
    obs_t o;
    ack_on = 2; slave_addr_data = 1'b0; slave_rdata = 32'hFFFF_FFFF;
    exp_q.push_back('{dat: 32'h0, err: 1'b0});
    exp_txn++;
    run_txn(1'b1, 17'h04004, 4'h1, 32'h0000_00A5, 0, o);
    n_checks++;
    if ({o.we, o.rd, o.stb, o.adr, o.wdat} !== {1'b1, 1'b0, 4'h1, 17'h04004, 32'h0000_00A5}) begin
      n_fail++;
      $display("FAIL write_bus: we=%b rd=%b stb=%h adr=%h dat=%h expected 1 0 1 04004 000000a5",
               o.we, o.rd, o.stb, o.adr, o.wdat);
    end
    n_checks++;
    if (o.cyc_len != 2) begin
      n_fail++;
      $display("FAIL write_cyc_len: got %0d expected 2", o.cyc_len);
    end
    check_rsp("write", o);
  endtask

  task automatic test_read();
    obs_t o;
    ack_on = 4; slave_addr_data = 1'b0; slave_rdata = 32'h0001_0000;
    exp_q.push_back('{dat: 32'h0001_0000, err: 1'b0});
    exp_txn++;
    run_txn(1'b0, 17'h05003, 4'h2, 32'h1234_5678, 0, o);
    n_checks++;
    if ({o.we, o.rd, o.stb, o.adr} !== {1'b0, 1'b1, 4'hF, 17'h05000}) begin
      n_fail++;
      $display("FAIL read_bus: we=%b rd=%b stb=%h adr=%h expected 0 1 f 05000", o.we, o.rd, o.stb, o.adr);
    end
    n_checks++;
    if (o.cyc_len != 4) begin
      n_fail++;
      $display("FAIL read_cyc_len: got %0d expected 4", o.cyc_len);
    end
    check_rsp("read", o);
  endtask

  task automatic test_timeout();
`ifdef WB_INITIATOR_TIMEOUT_EN
    obs_t o;
    ack_on = 0;
    exp_q.push_back('{dat: 32'hBAD_FAB_AC, err: 1'b1});
    exp_txn++;
    run_txn(1'b0, 17'h06000, 4'hF, 32'h0, 0, o);
    n_checks++;
    if (o.cyc_len != 7) begin
      n_fail++;
      $display("FAIL timeout_cyc_len: got %0d expected 7", o.cyc_len);
    end
    check_rsp("timeout", o);
`else
    int high = 0;
    ack_on = 0;
    Req_Valid_i = 1'b1; Req_WE_i = 1'b0; Req_ADR_i = 17'h06000; Req_BYTE_STB_i = 4'hF;
    @(negedge WBs_CLK_i);
    Req_Valid_i = 1'b0;
    for (int t = 0; t < 120; t++) begin
      if (WBm_CYC_o === 1'b1 && Rsp_Valid_o === 1'b0) high++;
      @(negedge WBs_CLK_i);
    end
    n_checks++;
    if (high != 120) begin
      n_fail++;
      $display("FAIL no_timeout_cyc_held: got %0d expected 120", high);
    end
    n_checks++;
    if (Rsp_Err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_err: got %b expected 0", Rsp_Err_o);
    end
    apply_reset();
`endif
  endtask

  task automatic test_ack_at_expiry();
    obs_t o;
    ack_on = 7; slave_addr_data = 1'b0; slave_rdata = 32'h5A5A_1234;
    exp_q.push_back('{dat: 32'h5A5A_1234, err: 1'b0});
    exp_txn++;
    run_txn(1'b0, 17'h00010, 4'hF, 32'h0, 0, o);
    n_checks++;
    if (o.cyc_len != 7) begin
      n_fail++;
      $display("FAIL ack_expiry_cyc_len: got %0d expected 7", o.cyc_len);
    end
    check_rsp("ack_expiry", o);
  endtask

  task automatic test_backpressure();
    obs_t o;
    ack_on = 1; slave_addr_data = 1'b0; slave_rdata = 32'h0BAD_CAFE;
    exp_q.push_back('{dat: 32'h0BAD_CAFE, err: 1'b0});
    exp_txn++;
    run_txn(1'b0, 17'h00124, 4'hF, 32'h0, 5, o);
    n_checks++;
    if (o.hold_bad) begin
      n_fail++;
      $display("FAIL backpressure_hold: unstable response 1 expected 0");
    end
    check_rsp("backpressure", o);
  endtask

  task automatic test_back_to_back();
    int            issued = 0, done = 0;
    int            rises[$];
    logic          prev_cyc = 1'b0;
    logic [AW-1:0] a;
    exp_t          e;
    ack_on = 1; slave_addr_data = 1'b1; Rsp_Ready_i = 1'b1;
    for (int t = 0; t < 200 && done < 4; t++) begin
      if (Req_Ready_o && issued < 4) begin
        a = AW'(17'h00103 + issued * 17'h00110);
        Req_Valid_i = 1'b1; Req_WE_i = 1'b0; Req_ADR_i = a; Req_BYTE_STB_i = 4'h0;
        exp_q.push_back('{dat: 32'hC0DE_0000 | 32'({a[AW-1:2], 2'b00}), err: 1'b0});
        issued++;
      end else if (Req_Ready_o) begin
        Req_Valid_i = 1'b0;
      end
      @(negedge WBs_CLK_i);
      if (WBm_CYC_o && !prev_cyc) rises.push_back(t);
      prev_cyc = WBm_CYC_o;
      if (Rsp_Valid_o) begin
        done++;
        exp_txn++;
        e = exp_q.pop_front();
        n_checks++;
        if ({Rsp_DAT_o, Rsp_Err_o} !== {e.dat, e.err}) begin
          n_fail++;
          $display("FAIL b2b_rsp%0d: dat=%h err=%b expected dat=%h err=%b", done, Rsp_DAT_o, Rsp_Err_o, e.dat, e.err);
        end
      end
    end
    Req_Valid_i = 1'b0;
    @(negedge WBs_CLK_i);
    n_checks++;
    if (done != 4 || rises.size() != 4) begin
      n_fail++;
      $display("FAIL b2b_count: done=%0d cycles=%0d expected 4 4", done, rises.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (rises[i] - rises[i-1] != 3) begin
          n_fail++;
          $display("FAIL b2b_spacing%0d: got %0d expected 3", i, rises[i] - rises[i-1]);
        end
      end
    end
    n_checks++;
    if (Txn_Cnt_o !== exp_txn) begin
      n_fail++;
      $display("FAIL b2b_txn_cnt: got %h expected %h", Txn_Cnt_o, exp_txn);
    end
  endtask

  task automatic test_reset_mid_bus();
    ack_on = 0;
    Req_Valid_i = 1'b1; Req_WE_i = 1'b1; Req_ADR_i = 17'h00200; Req_BYTE_STB_i = 4'h3; Req_DAT_i = 32'h1;
    @(negedge WBs_CLK_i);
    Req_Valid_i = 1'b0;
    repeat (2) @(negedge WBs_CLK_i);
    n_checks++;
    if (WBm_CYC_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_precond_cyc: got %b expected 1", WBm_CYC_o);
    end
    WBs_RST_i = 1'b1;
    @(negedge WBs_CLK_i);
    n_checks++;
    if ({WBm_CYC_o, WBm_STB_o, Req_Ready_o, Rsp_Valid_o} !== 4'b0010 || Txn_Cnt_o !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_bus: cyc=%b stb=%b rdy=%b vld=%b cnt=%h expected 0 0 1 0 0000",
               WBm_CYC_o, WBm_STB_o, Req_Ready_o, Rsp_Valid_o, Txn_Cnt_o);
    end
    WBs_RST_i = 1'b0;
    exp_txn = 16'd0;
    exp_q.delete();
    @(negedge WBs_CLK_i);
  endtask

  task automatic test_txn_wrap();
    obs_t o;
    force dut.txn_cnt_q = 16'hFFFF;
    @(negedge WBs_CLK_i);
    release dut.txn_cnt_q;
    @(negedge WBs_CLK_i);
    n_checks++;
    if (Txn_Cnt_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h expected ffff", Txn_Cnt_o);
    end
    ack_on = 1; slave_addr_data = 1'b0;
    exp_q.push_back('{dat: 32'h0, err: 1'b0});
    exp_txn = 16'h0000;
    run_txn(1'b1, 17'h00300, 4'hC, 32'hAAAA_5555, 0, o);
    check_rsp("wrap", o);
  endtask

  initial begin
    WBs_RST_i = 1'b1; Req_Valid_i = 1'b0; Req_WE_i = 1'b0; Req_ADR_i = '0;
    Req_BYTE_STB_i = '0; Req_DAT_i = '0; Rsp_Ready_i = 1'b1;
    @(negedge WBs_CLK_i);
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_expiry();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_bus();
    test_txn_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
